// File: rtl/crc_pkg.sv
// Shared defaults and FSM state encoding for the CRC frame serializer.
package crc_pkg;

  localparam int           MSG_W_DEF = 10;
  localparam int           CRC_W_DEF = 9;
  localparam logic [8:0]   POLY_DEF  = 9'h103;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    CRC  = 2'd2
  } state_t;

endpackage

// File: rtl/crc9_serial_lfsr.sv
// Bit-serial CRC LFSR (init 0, MSB-first feedback); used only when
// CRC_FRAME_CHECK_EN is defined.
module crc9_serial_lfsr
  import crc_pkg::*;
#(
  parameter int               CRC_W = CRC_W_DEF,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(POLY_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             enable,
  input  logic             clear,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_q, crc_d;
  logic             fb;

  always_comb begin
    fb    = bit_in ^ crc_q[CRC_W-1];
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc_frame_serializer.sv
// Serializes {msg, crc} MSB first with sof/eof framing. Optional receive-side
// CRC recheck is enabled by defining CRC_FRAME_CHECK_EN.
module crc_frame_serializer
  import crc_pkg::*;
#(
  parameter int               MSG_W = MSG_W_DEF,
  parameter int               CRC_W = CRC_W_DEF,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(POLY_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [MSG_W-1:0] msg_in,
  input  logic [CRC_W-1:0] crc_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             out_ready,
  output logic             sof,
  output logic             eof,
  output logic             crc_err,
  output logic [1:0]       dbg_state
);

  localparam int               FRAME_W  = MSG_W + CRC_W;
  localparam int               CNT_W    = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_MSG = CNT_W'(MSG_W - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  // Handshakes: a frame is taken when in_valid && in_ready at a rising edge;
  // a bit is consumed when ser_valid && out_ready at a rising edge. All
  // outputs come straight from flops, so neither ready depends on a valid.
  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 ser_valid_q, ser_valid_d;
  logic                 ser_out_q, ser_out_d;
  logic                 sof_q, sof_d;
  logic                 eof_q, eof_d;
  logic                 accept_frame, accept_bit;

`ifdef CRC_FRAME_CHECK_EN
  logic [CRC_W-1:0] crc_lat_q, crc_lat_d;
  logic             crc_err_q, crc_err_d;
  logic [CRC_W-1:0] lfsr_crc;

  crc9_serial_lfsr #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .bit_in (sr_q[FRAME_W-1]),
    .enable ((state_q == MSG) && accept_bit),
    .clear  (accept_frame),
    .crc    (lfsr_crc)
  );
`endif

  always_comb begin
    accept_frame = in_ready_q && in_valid;
    accept_bit   = ser_valid_q && out_ready;
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept_frame) begin
          state_d = MSG;
          sr_d    = {msg_in, crc_in};
          cnt_d   = '0;
        end
      end
      MSG: begin
        if (accept_bit) begin
          sr_d  = {sr_q[FRAME_W-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_MSG) state_d = CRC;
        end
      end
      CRC: begin
        if (accept_bit) begin
          sr_d  = {sr_q[FRAME_W-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are precomputed from next state so they register alongside it.
    in_ready_d  = (state_d == IDLE);
    ser_valid_d = !in_ready_d;
    ser_out_d   = ser_valid_d && sr_d[FRAME_W-1];
    sof_d       = ser_valid_d && (cnt_d == '0);
    eof_d       = ser_valid_d && (cnt_d == LAST_BIT);

`ifdef CRC_FRAME_CHECK_EN
    crc_lat_d = crc_lat_q;
    crc_err_d = crc_err_q;
    if (accept_frame) begin
      crc_lat_d = crc_in;
      crc_err_d = 1'b0;
    end
    if ((state_q == CRC) && accept_bit && (cnt_q == LAST_BIT)) begin
      crc_err_d = (lfsr_crc != crc_lat_q);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      ser_valid_q <= 1'b0;
      ser_out_q   <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
`ifdef CRC_FRAME_CHECK_EN
      crc_lat_q   <= '0;
      crc_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      ser_valid_q <= ser_valid_d;
      ser_out_q   <= ser_out_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
`ifdef CRC_FRAME_CHECK_EN
      crc_lat_q   <= crc_lat_d;
      crc_err_q   <= crc_err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign ser_valid = ser_valid_q;
  assign ser_out   = ser_out_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign dbg_state = state_q;
`ifdef CRC_FRAME_CHECK_EN
  assign crc_err   = crc_err_q;
`else
  assign crc_err   = 1'b0;
`endif

endmodule

// File: doc/crc_frame_serializer.md
CRC_FRAME_SERIALIZER -- requirements
Module: crc_frame_serializer

Interface
REQ-001 Parameter MSG_W, 10, message width in bits.
REQ-002 Parameter CRC_W, 9, CRC width in bits.
REQ-003 Parameter POLY, 9'h103, generator 1+y+y8+y9 without the implicit y9 term.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 msg_in  input  MSG_W  message word from the CRC pipeline stage.
REQ-007 crc_in  input  CRC_W  CRC of msg_in (data_out of the CRC pipeline stage).
REQ-008 in_valid  input  1  msg_in/crc_in valid.
REQ-009 in_ready  output  1  block can accept a frame.
REQ-010 ser_out  output  1  serial codeword bit.
REQ-011 ser_valid  output  1  ser_out valid.
REQ-012 out_ready  input  1  downstream accepts the current bit.
REQ-013 sof  output  1  current bit is the first bit of the frame.
REQ-014 eof  output  1  current bit is the last bit of the frame.
REQ-015 crc_err  output  1  CRC mismatch flag of the last completed frame.

Function
REQ-016 Frame = msg_in MSB first, then crc_in MSB first; MSG_W+CRC_W bits (19 by default).
REQ-017 FSM states IDLE, MSG, CRC; IDLE->MSG on in_valid&&in_ready; MSG->CRC after bit MSG_W-1 is accepted; CRC->IDLE after bit CRC_W-1 is accepted.
REQ-018 in_ready = 1 only in IDLE; in_valid outside IDLE is ignored; one idle cycle always separates frames.
REQ-019 On accept, msg_in and crc_in are latched into a (MSG_W+CRC_W)-bit shift register, and the bit counter is cleared.
REQ-020 ser_valid = 1 in MSG and CRC; first bit is presented the cycle after accept.
REQ-021 A bit is accepted when ser_valid&&out_ready; only then does the shift register advance and the counter increment.
REQ-022 With out_ready low, ser_out, sof, eof and state hold unchanged.
REQ-023 sof = 1 while bit index 0 is presented; eof = 1 while bit index MSG_W+CRC_W-1 is presented.
REQ-024 All outputs are driven from registered state only; there is no combinational path from any input to any output.
REQ-025 With out_ready tied high, bits occupy cycles 1..19 after accept, and in_ready is high on cycle 20.

Reset
REQ-026 reset low asynchronously forces IDLE, clears the counter, shift register and crc_err, and drives in_ready=1, ser_valid=0, ser_out=0, sof=0, eof=0.
REQ-027 reset asserted mid-frame discards the frame; no partial eof is produced; after release the block is in IDLE.

Configuration
REQ-028 Macro CRC_FRAME_CHECK_EN defined: a serial LFSR (init 0, fb = bit ^ r[CRC_W-1], r = {r<<1} ^ (fb ? POLY : 0)) consumes each accepted MSG bit; at the CRC->IDLE transition, crc_err is registered as (LFSR != latched crc_in); crc_err holds until the next accept, which clears it.
REQ-029 Macro CRC_FRAME_CHECK_EN undefined: no LFSR logic is present, and crc_err is tied to 0; all other behaviour is identical.

Structure
REQ-030 Package crc_pkg holds the MSG_W/CRC_W/POLY defaults and the FSM state typedef (IDLE, MSG, CRC).
REQ-031 Sub-module crc9_serial_lfsr (bit, enable, clear, crc) is instantiated only under CRC_FRAME_CHECK_EN.

Verification
REQ-032 msg 10'b1100000011, crc 9'h000, out_ready=1 -> 19 bits 1100000011_000000000, sof on cycle 1, eof on cycle 19, crc_err=0.
REQ-033 msg 10'h001, crc 9'h103 -> bits 0000000001_100000011, crc_err=0 (macro on).
REQ-034 msg 10'h001, crc 9'h000 -> crc_err=1 after eof with macro on; crc_err=0 with macro off.
REQ-035 out_ready toggled 0/1 every cycle -> same 19-bit sequence, each bit held while out_ready=0, frame spans 38 cycles.
REQ-036 in_valid held high continuously -> frames are accepted only in IDLE, with one idle cycle between the eof bit and the next sof.
REQ-037 reset pulsed low at bit 7 of a frame -> ser_valid drops immediately, no eof occurs, and in_ready=1 after release.
